// File: rtl/rx_frame_buffer_if.sv
// Stream bundle between the depacketizer, the receive frame buffer and the host-side sink.
//   s_tdata/s_tvalid/s_tlast/s_tuser : received byte stream (no ready, never stalls)
//   m_tdata/m_tvalid/m_tlast/m_tready: buffered AXI-Stream output with backpressure
// Modports:
//   master : environment side, sources received bytes and sinks buffered bytes
//   slave  : buffer side, consumes received bytes and sources buffered bytes
interface rx_frame_buffer_if;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tuser;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tready;

    modport master (
        output s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
        input  m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
        output m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive frame buffer. Frames are accumulated in a circular byte RAM and
// only made visible to the reader once complete and (in CRC mode) CRC-8 clean; the CRC byte
// is stripped. Bad, runt, oversize and overflowing frames are rewound and counted.
// Ports:
//   clk_32M768      : sole clock
//   rst_n_32M768    : asynchronous active-low reset
//   bus             : receive stream in (s_*) and buffered stream out (m_*), slave view
//   frames_ok       : committed frames, saturating
//   frames_bad_crc  : CRC failures, saturating
//   frames_dropped  : overflow/runt/oversize drops, saturating
//   frame_err       : one-cycle pulse on any discard
module rx_frame_buffer #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned MAX_FRAME = 64,
    parameter logic [7:0]  CRC_POLY  = 8'h07
) (
    input  logic             clk_32M768,
    input  logic             rst_n_32M768,
    rx_frame_buffer_if.slave bus,
    output logic [15:0]      frames_ok,
    output logic [15:0]      frames_bad_crc,
    output logic [15:0]      frames_dropped,
    output logic             frame_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(MAX_FRAME + 2);

    typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

    state_e        r_state, w_state_nxt;
    logic          r_mode, w_mode_nxt;
    logic [7:0]    r_crc, w_crc_nxt;
    logic [7:0]    r_hold, w_hold_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [PW-1:0] r_commit_ptr, w_commit_ptr_nxt;
    logic [PW-1:0] r_rd_ptr;
    logic [8:0]    r_mem [DEPTH];
    logic          r_m_tvalid;
    logic [7:0]    r_m_tdata;
    logic          r_m_tlast;
    logic [15:0]   r_ok, r_bad, r_drop;
    logic          r_err;

    logic          w_we;
    logic [8:0]    w_wdata;
    logic          w_rd_en;
    logic [8:0]    w_rd_word;
    logic [PW-1:0] w_used_after;
    logic          w_full;
    logic [7:0]    w_crc_calc;
    logic [CW-1:0] w_cnt_inc;
    logic          w_inc_ok, w_inc_bad, w_inc_drop;

    // MSB-first CRC-8, no reflection, no final XOR.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ data[i]) c = (c << 1) ^ CRC_POLY;
            else                c = c << 1;
        end
        return c;
    endfunction

    // Reader only sees committed entries; output register refills when empty or being taken.
    assign w_rd_en   = (r_rd_ptr != r_commit_ptr) && (!r_m_tvalid || bus.m_tready);
    assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];

    // Occupancy after this cycle's read, so a same-cycle read can make room for a write.
    assign w_used_after = r_wr_ptr - (r_rd_ptr + {{AW{1'b0}}, w_rd_en});
    assign w_full       = (w_used_after == PW'(DEPTH));

    assign w_crc_calc = crc8_step((r_state == StIdle) ? 8'h00 : r_crc, bus.s_tdata);
    assign w_cnt_inc  = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_mode_nxt       = r_mode;
        w_crc_nxt        = r_crc;
        w_hold_nxt       = r_hold;
        w_cnt_nxt        = r_cnt;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_we             = 1'b0;
        w_wdata          = {bus.s_tlast, bus.s_tdata};
        w_inc_ok         = 1'b0;
        w_inc_bad        = 1'b0;
        w_inc_drop       = 1'b0;

        if (bus.s_tvalid) begin
            unique case (r_state)
                StIdle: begin
                    w_mode_nxt = bus.s_tuser;
                    w_crc_nxt  = w_crc_calc;
                    w_hold_nxt = bus.s_tdata;
                    w_cnt_nxt  = CW'(1);
                    if (bus.s_tuser) begin
                        if (w_full) begin
                            if (bus.s_tlast) w_inc_drop  = 1'b1;
                            else             w_state_nxt = StDrop;
                        end else begin
                            w_we         = 1'b1;
                            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                            if (bus.s_tlast) begin
                                w_commit_ptr_nxt = r_wr_ptr + 1'b1;
                                w_inc_ok         = 1'b1;
                            end else begin
                                w_state_nxt = StRecv;
                            end
                        end
                    end else if (bus.s_tlast) begin
                        // Lone CRC byte with no payload.
                        w_inc_drop = 1'b1;
                    end else begin
                        w_state_nxt = StRecv;
                    end
                end

                StRecv: begin
                    w_crc_nxt  = w_crc_calc;
                    w_hold_nxt = bus.s_tdata;
                    w_cnt_nxt  = w_cnt_inc;
                    // CRC mode writes the delayed byte so the CRC byte itself never lands.
                    if (!r_mode) w_wdata = {bus.s_tlast, r_hold};
                    if ((w_cnt_inc > CW'(MAX_FRAME)) || w_full) begin
                        if (bus.s_tlast) begin
                            w_wr_ptr_nxt = r_commit_ptr;
                            w_inc_drop   = 1'b1;
                            w_state_nxt  = StIdle;
                        end else begin
                            w_state_nxt = StDrop;
                        end
                    end else begin
                        w_we         = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                        if (bus.s_tlast) begin
                            w_state_nxt = StIdle;
                            if (r_mode || (w_crc_calc == 8'h00)) begin
                                w_commit_ptr_nxt = r_wr_ptr + 1'b1;
                                w_inc_ok         = 1'b1;
                            end else begin
                                w_wr_ptr_nxt = r_commit_ptr;
                                w_inc_bad    = 1'b1;
                            end
                        end
                    end
                end

                StDrop: begin
                    if (bus.s_tlast) begin
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_inc_drop   = 1'b1;
                        w_state_nxt  = StIdle;
                    end
                end

                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
        if (!rst_n_32M768) begin
            r_state      <= StIdle;
            r_mode       <= 1'b0;
            r_crc        <= 8'h00;
            r_hold       <= 8'h00;
            r_cnt        <= '0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mode       <= w_mode_nxt;
            r_crc        <= w_crc_nxt;
            r_hold       <= w_hold_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_commit_ptr <= w_commit_ptr_nxt;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk_32M768) begin
        if (w_we) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
    end

    always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
        if (!rst_n_32M768) begin
            r_rd_ptr   <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= 8'h00;
            r_m_tlast  <= 1'b0;
        end else if (w_rd_en) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_rd_word[7:0];
            r_m_tlast  <= w_rd_word[8];
        end else if (bus.m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
        if (!rst_n_32M768) begin
            r_ok   <= 16'h0000;
            r_bad  <= 16'h0000;
            r_drop <= 16'h0000;
            r_err  <= 1'b0;
        end else begin
            if (w_inc_ok && (r_ok != 16'hFFFF))    r_ok   <= r_ok + 16'd1;
            if (w_inc_bad && (r_bad != 16'hFFFF))  r_bad  <= r_bad + 16'd1;
            if (w_inc_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
            r_err <= w_inc_drop | w_inc_bad;
        end
    end

    assign bus.m_tdata    = r_m_tdata;
    assign bus.m_tvalid   = r_m_tvalid;
    assign bus.m_tlast    = r_m_tlast;
    assign frames_ok      = r_ok;
    assign frames_bad_crc = r_bad;
    assign frames_dropped = r_drop;
    assign frame_err      = r_err;
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Bench for rx_frame_buffer with a small buffer (DEPTH 16, MAX_FRAME 12) so that overflow,
// oversize and pointer wrap are all reachable with short frames.
module tb_rx_frame_buffer;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXF  = 12;
    localparam logic [7:0]  POLY  = 8'h07;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] frames_ok;
    logic [15:0] frames_bad_crc;
    logic [15:0] frames_dropped;
    logic        frame_err;

    rx_frame_buffer_if bus ();

    rx_frame_buffer #(
        .DEPTH    (DEPTH),
        .MAX_FRAME(MAXF),
        .CRC_POLY (POLY)
    ) dut (
        .clk_32M768    (clk),
        .rst_n_32M768  (rst_n),
        .bus           (bus),
        .frames_ok     (frames_ok),
        .frames_bad_crc(frames_bad_crc),
        .frames_dropped(frames_dropped),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         errors   = 0;
    logic [8:0] q[$];          // expected output words {last, data}
    logic [7:0] fr[$];         // frame being sent
    int         exp_ok   = 0;
    int         exp_bad  = 0;
    int         exp_drop = 0;
    bit         rdy_rand = 1'b0;
    logic       v_at_e0;
    int         ncyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte-wise CRC-8 over the first k bytes of fr.
    function automatic logic [7:0] crc_of(input int k);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < k; i++) begin
            c = c ^ fr[i];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    // One clock: score a transfer before the edge, check holding after it.
    task automatic cycle();
        logic       held;
        logic [8:0] held_word;
        logic [8:0] e;
        held      = bus.m_tvalid && !bus.m_tready;
        held_word = {bus.m_tlast, bus.m_tdata};
        if (bus.m_tvalid && bus.m_tready) begin
            chk("out_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_byte", {23'd0, bus.m_tlast, bus.m_tdata}, {23'd0, e});
            end
        end
        @(posedge clk);
        #1;
        if (held) chk("hold_stable", {bus.m_tvalid, bus.m_tlast, bus.m_tdata}, {1'b1, held_word});
        if (rdy_rand) bus.m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic check_counters();
        chk("frames_ok", frames_ok, exp_ok);
        chk("frames_bad_crc", frames_bad_crc, exp_bad);
        chk("frames_dropped", frames_dropped, exp_drop);
    endtask

    // Sends fr; ram_used is the number of committed bytes still occupying RAM slots.
    task automatic send_frame(input logic user, input int ram_used, input bit gaps);
        int n;
        int writes;
        bit drop;
        bit bad;
        n = fr.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 1)) cycle();
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = fr[i];
            bus.s_tlast  = (i == n - 1);
            bus.s_tuser  = (i == 0) ? user : 1'($urandom_range(0, 1));
            cycle();
            bus.s_tvalid = 1'b0;
            bus.s_tlast  = 1'b0;
            bus.s_tuser  = 1'b0;
        end
        v_at_e0 = bus.m_tvalid;
        writes = user ? n : n - 1;
        drop   = (n > int'(MAXF)) || (!user && n == 1) || (ram_used + writes > int'(DEPTH));
        bad    = !drop && !user && (crc_of(n) != 8'h00);
        if (drop) exp_drop++;
        else if (bad) exp_bad++;
        else begin
            exp_ok++;
            for (int i = 0; i < writes; i++) q.push_back({(i == writes - 1), fr[i]});
        end
        chk("frame_err_pulse", frame_err, drop || bad);
        check_counters();
        cycle();
        chk("frame_err_end", frame_err, 0);
    endtask

    task automatic drain(output int used);
        used = 0;
        while (q.size() != 0 && used < 400) begin
            cycle();
            used++;
        end
        chk("drain_done", q.size(), 0);
        chk("idle_after_drain", bus.m_tvalid, 0);
    endtask

    task automatic wait_room();
        int k;
        k = 0;
        while (q.size() > 4 && k < 400) begin
            cycle();
            k++;
        end
        chk("room_available", 32'(q.size() <= 4), 1);
    endtask

    task automatic load_str(input logic [7:0] first, input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(first + 8'(i));
    endtask

    task automatic load_rand(input int n);
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    endtask

    initial begin
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'h00;
        bus.s_tlast  = 1'b0;
        bus.s_tuser  = 1'b0;
        bus.m_tready = 1'b1;

        // Reset values.
        #12;
        chk("rst_m_tvalid", bus.m_tvalid, 0);
        chk("rst_m_tdata", bus.m_tdata, 0);
        chk("rst_m_tlast", bus.m_tlast, 0);
        chk("rst_frame_err", frame_err, 0);
        check_counters();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Good CRC frame "123456789" + 0xF4.
        load_str(8'h31, 9);
        fr.push_back(8'hF4);
        send_frame(1'b0, 0, 1'b0);
        chk("latency_e0", v_at_e0, 0);
        chk("latency_e1", bus.m_tvalid, 1);
        drain(ncyc);
        chk("throughput", ncyc, 9);

        // Bad CRC, then an intact good frame.
        load_str(8'h31, 9);
        fr.push_back(8'hF5);
        send_frame(1'b0, 0, 1'b0);
        repeat (3) cycle();
        chk("bad_no_output", bus.m_tvalid, 0);
        load_str(8'h31, 9);
        fr.push_back(8'hF4);
        send_frame(1'b0, 0, 1'b0);
        drain(ncyc);

        // Raw frame.
        fr.delete();
        fr.push_back(8'hAA);
        fr.push_back(8'hBB);
        fr.push_back(8'hCC);
        send_frame(1'b1, 0, 1'b0);
        drain(ncyc);

        // Runt and oversize, then a frame proving nothing leaked.
        load_rand(1);
        send_frame(1'b0, 0, 1'b0);
        load_rand(MAXF + 1);
        send_frame(1'b1, 0, 1'b0);
        repeat (2) cycle();
        chk("drop_no_output", bus.m_tvalid, 0);
        load_rand(MAXF);
        send_frame(1'b1, 0, 1'b0);
        drain(ncyc);

        // Overflow under backpressure; output register holds one byte, freeing its slot.
        bus.m_tready = 1'b0;
        load_rand(8);
        send_frame(1'b1, 0, 1'b0);
        load_rand(9);                       // fills RAM exactly
        send_frame(1'b1, q.size() - 1, 1'b0);
        load_rand(1);                       // full on first beat
        send_frame(1'b1, q.size() - 1, 1'b0);
        load_rand(2);
        send_frame(1'b1, q.size() - 1, 1'b0);
        load_rand(6);
        fr.push_back(crc_of(6));
        send_frame(1'b0, q.size() - 1, 1'b0);
        rdy_rand = 1'b1;
        drain(ncyc);

        // Randomized frames with random backpressure and beat gaps.
        for (int f = 0; f < 40; f++) begin
            logic user;
            int   kind;
            int   len;
            logic [7:0] c;
            wait_room();
            user = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 9);
            len  = (kind == 0) ? int'(MAXF) + 1 : $urandom_range(1, MAXF);
            if (user) load_rand(len);
            else begin
                load_rand(len - 1);
                c = crc_of(len - 1);
                if (kind == 1) c = c ^ 8'($urandom_range(1, 255));
                fr.push_back(c);
            end
            send_frame(user, q.size(), 1'b1);
        end
        drain(ncyc);

        // Reset with one buffered frame and a partial frame in flight.
        rdy_rand     = 1'b0;
        bus.m_tready = 1'b0;
        load_rand(4);
        send_frame(1'b1, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = 8'(i + 1);
            bus.s_tuser  = 1'b0;
            cycle();
        end
        bus.s_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_ok   = 0;
        exp_bad  = 0;
        exp_drop = 0;
        chk("mid_rst_m_tvalid", bus.m_tvalid, 0);
        chk("mid_rst_m_tdata", bus.m_tdata, 0);
        chk("mid_rst_m_tlast", bus.m_tlast, 0);
        chk("mid_rst_frame_err", frame_err, 0);
        check_counters();
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = 8'h5A;
        bus.s_tlast  = 1'b1;
        bus.s_tuser  = 1'b1;
        repeat (2) @(posedge clk);
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.s_tuser  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.m_tready = 1'b1;
        cycle();
        chk("post_rst_empty", bus.m_tvalid, 0);
        load_str(8'h31, 9);
        fr.push_back(8'hF4);
        send_frame(1'b0, 0, 1'b0);
        drain(ncyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
